// File: rtl/draw_pkg.sv
// Shared definitions for the draw slot scheduler: state encoding and default geometry.
// The legacy free-running sweep is selected with DRAW_SLOT_SCHED_LEGACY_EN (see top).
package draw_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DRAW = ST_DRAW,
    S_ACK  = ST_ACK
  } state_e;

  localparam int X_W                 = 8;
  localparam int Y_W                 = 8;
  localparam int COL_W               = 9;
  localparam int SLOT_CYCLES_DEFAULT = 41;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first request after the last pointer wins.
module rr_picker #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic              vld_o,
  output logic [CH_W-1:0]   win_o
);

  // Scan from farthest to nearest so the nearest candidate after last_i is written last.
  always_comb begin
    vld_o = |req_i;
    win_o = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % NUM_CH])
        win_o = CH_W'((int'(last_i) + k) % NUM_CH);
    end
  end

endmodule

// File: rtl/draw_slot_scheduler.sv
// Time-shares one VGA plot port among NUM_CH sprite channels in SLOT_CYCLES-long slots.
// Define DRAW_SLOT_SCHED_LEGACY_EN for the legacy free-running sweep over all channels.
module draw_slot_scheduler #(
  parameter int  NUM_CH      = 6,
  parameter int  SLOT_CYCLES = draw_pkg::SLOT_CYCLES_DEFAULT,
  parameter int  X_W         = draw_pkg::X_W,
  parameter int  Y_W         = draw_pkg::Y_W,
  parameter int  COL_W       = draw_pkg::COL_W,
  localparam int CH_W        = draw_pkg::ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH*X_W-1:0]   ch_x,
  input  logic [NUM_CH*Y_W-1:0]   ch_y,
  input  logic [NUM_CH*COL_W-1:0] ch_colour,
  input  logic [NUM_CH-1:0]       ch_dirty,
  output logic [NUM_CH-1:0]       ch_ack,
  output logic [CH_W-1:0]         cur_ch,
  output logic [X_W-1:0]          x_out,
  output logic [Y_W-1:0]          y_out,
  output logic [COL_W-1:0]        colour_out,
  output logic                    plot
);
  import draw_pkg::*;

  localparam int              SC_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CH_W-1:0]     cur_q, cur_d;
  logic [SC_W-1:0]     slot_q, slot_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                plot_q, plot_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;

  logic [NUM_CH-1:0]   clr, cand;
  logic                pick_vld;
  logic [CH_W-1:0]     pick_win;

  // The finishing channel is cleared before the choice, so it only wins again on a fresh request.
  assign clr       = (state_q == S_ACK) ? (NUM_CH'(1) << cur_q) : '0;
  assign pending_d = (pending_q & ~clr) | ch_dirty;

`ifdef DRAW_SLOT_SCHED_LEGACY_EN
  assign cand = '1;
`else
  assign cand = pending_d;
`endif

  rr_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .req_i  (cand),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .win_o  (pick_win)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    slot_d  = slot_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_DRAW;
          cur_d   = pick_win;
          last_d  = pick_win;
          slot_d  = '0;
        end
      end
      S_DRAW: begin
        x_d    = ch_x[int'(cur_q)*X_W +: X_W];
        y_d    = ch_y[int'(cur_q)*Y_W +: Y_W];
        col_d  = ch_colour[int'(cur_q)*COL_W +: COL_W];
        plot_d = 1'b1;
        slot_d = slot_q + 1'b1;
        if (slot_q == SC_LAST) state_d = S_ACK;
      end
      S_ACK: begin
        ack_d[cur_q] = 1'b1;
        if (pick_vld) begin
          state_d = S_DRAW;
          cur_d   = pick_win;
          last_d  = pick_win;
          slot_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      last_q    <= CH_W'(NUM_CH - 1);
      cur_q     <= '0;
      slot_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      plot_q    <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      slot_q    <= slot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      plot_q    <= plot_d;
      ack_q     <= ack_d;
    end
  end

  assign ch_ack     = ack_q;
  assign cur_ch     = cur_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_draw_slot_scheduler.sv
// Scoreboard bench: a slot-level reference model predicts grants, a negedge monitor checks the plot port.
module tb_draw_slot_scheduler;
  localparam int NUM_CH = 6;
  localparam int S      = 41;
  localparam int X_W    = 8;
  localparam int Y_W    = 8;
  localparam int COL_W  = 9;
  localparam int CH_W   = 3;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic [NUM_CH*X_W-1:0]   ch_x = '0;
  logic [NUM_CH*Y_W-1:0]   ch_y = '0;
  logic [NUM_CH*COL_W-1:0] ch_colour = '0;
  logic [NUM_CH-1:0]       ch_dirty = '0;
  logic [NUM_CH-1:0]       ch_ack;
  logic [CH_W-1:0]         cur_ch;
  logic [X_W-1:0]          x_out;
  logic [Y_W-1:0]          y_out;
  logic [COL_W-1:0]        colour_out;
  logic                    plot;

  always #5 clk = ~clk;

  draw_slot_scheduler #(.NUM_CH(NUM_CH), .SLOT_CYCLES(S), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W)) dut (
    .clk(clk), .resetn(resetn), .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_colour),
    .ch_dirty(ch_dirty), .ch_ack(ch_ack), .cur_ch(cur_ch), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { int ch; int g; } slot_t;
  slot_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: slot owner, edges since grant, pending set, round-robin pointer.
  int  cyc = 0;
  bit  pend [NUM_CH];
  int  owner = -1;
  int  mt = 0;
  int  mlast = NUM_CH - 1;
  bit  decide;
  logic [X_W-1:0]   sx [NUM_CH];
  logic [Y_W-1:0]   sy [NUM_CH];
  logic [COL_W-1:0] sc [NUM_CH];

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b0;
      owner = -1;
      mt    = 0;
      mlast = NUM_CH - 1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sx[i] = ch_x[i*X_W +: X_W];
        sy[i] = ch_y[i*Y_W +: Y_W];
        sc[i] = ch_colour[i*COL_W +: COL_W];
      end
      decide = (owner < 0);
      if (owner >= 0) begin
        mt++;
        if (mt == S + 1) begin
          pend[owner] = 1'b0;
          decide = 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) if (ch_dirty[i]) pend[i] = 1'b1;
`ifdef DRAW_SLOT_SCHED_LEGACY_EN
      for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b1;
`endif
      if (decide) begin
        owner = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
          int c;
          c = (mlast + k) % NUM_CH;
          if (pend[c] && owner < 0) owner = c;
        end
        if (owner >= 0) begin
          mlast = owner;
          mt    = 0;
          sbq.push_back('{owner, cyc});
        end
      end
    end
  end

  // Monitor
  bit                plot_prev = 1'b0;
  int                run_ch = 0;
  int                run_len = 0;
  logic [NUM_CH-1:0] exp_ack;
  slot_t             e;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_plot", plot, 0);
      chk("rst_ack", ch_ack, 0);
      chk("rst_cur", cur_ch, 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_col", colour_out, 0);
      plot_prev = 1'b0;
      sbq.delete();
    end else begin
      exp_ack = '0;
      if (plot_prev && !plot) begin
        chk("slot_len", run_len, S);
        exp_ack[run_ch] = 1'b1;
      end
      chk("ack", ch_ack, exp_ack);
      if (plot && !plot_prev) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_slot: got plot on ch %0d expected none", cur_ch);
          run_ch = int'(cur_ch) % NUM_CH;
        end else begin
          e = sbq.pop_front();
          chk("grant_ch", cur_ch, e.ch);
          chk("grant_time", cyc, e.g + 1);
          run_ch = e.ch;
        end
        run_len = 0;
      end
      if (plot) begin
        run_len++;
        chk("x", x_out, sx[run_ch]);
        chk("y", y_out, sy[run_ch]);
        chk("col", colour_out, sc[run_ch]);
        chk("cur_hold", cur_ch, run_ch);
      end
      plot_prev = plot;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int i, input int x, input int y, input int c);
    ch_x[i*X_W +: X_W]         = X_W'(x);
    ch_y[i*Y_W +: Y_W]         = Y_W'(y);
    ch_colour[i*COL_W +: COL_W] = COL_W'(c);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    ch_dirty = m;
    tick();
    ch_dirty = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
`ifdef DRAW_SLOT_SCHED_LEGACY_EN
    repeat (bound / 4) tick();
`else
    while (!(owner < 0 && sbq.size() == 0 && !plot) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", n >= bound, 0);
`endif
  endtask

  task automatic wait_model(input int ch, input int t, input int bound);
    int n;
    n = 0;
    while (!(owner == ch && mt == t) && n < bound) begin
      tick();
      n++;
    end
    chk("wait_timeout", n >= bound, 0);
  endtask

  initial begin
    repeat (3) tick();
    resetn = 1'b1;

    // Idle after reset
    repeat (200) tick();
`ifndef DRAW_SLOT_SCHED_LEGACY_EN
    chk("idle_plot", plot, 0);
    chk("idle_cur", cur_ch, 0);
    chk("idle_ack", ch_ack, 0);
`endif

    // Single pulse on channel 2
    set_ch(2, 40, 12, 'h1C0);
    pulse(6'b000100);
    wait_idle(200);

    // Every channel continuously dirty: strict rotation
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 10 + i, 20 + i, 'h100 + i);
    ch_dirty = '1;
    repeat (7 * (S + 1)) tick();
    ch_dirty = '0;
    wait_idle(800);

    // Re-request during own ACK while another channel is pending
    do_reset();
    pulse(6'b010000);
    repeat (10) tick();
    pulse(6'b000010);
    wait_model(4, S, 200);
    pulse(6'b010000);
    wait_idle(400);

    // Asynchronous reset in the middle of a slot
    set_ch(3, 77, 88, 'h0AB);
    pulse(6'b001000);
    pulse(6'b100000);
    wait_model(3, 20, 200);
    #1;
    chk("pre_rst_plot", plot, 1);
    resetn = 1'b0;
    #1;
    chk("async_plot", plot, 0);
    chk("async_cur", cur_ch, 0);
    chk("async_x", x_out, 0);
    chk("async_col", colour_out, 0);
    chk("async_ack", ch_ack, 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (100) tick();
`ifndef DRAW_SLOT_SCHED_LEGACY_EN
    chk("post_rst_plot", plot, 0);
`endif

    // Random requests with channel fields changing every cycle
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++) ch_dirty[i] = ($urandom_range(0, 49) == 0);
      set_ch(int'($urandom_range(0, NUM_CH - 1)), int'($urandom), int'($urandom), int'($urandom));
      tick();
    end
    ch_dirty = '0;
    wait_idle(1000);

`ifndef DRAW_SLOT_SCHED_LEGACY_EN
    chk("end_queue", sbq.size(), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
